// File: rtl/skew_feeder_if.sv
// skew_feeder_if: write, start and stream signals of the skewed tile feeder.
// master drives the row writes, start/transpose and en (downstream ready);
// slave (the feeder) returns aout/out_valid and the busy/full/done/err flags.
interface skew_feeder_if #(
    parameter int DIM  = 8,
    parameter int BITS = 8
);
    logic                    wr_en;
    logic [$clog2(DIM)-1:0]  wr_row;
    logic [DIM*BITS-1:0]     wr_data;
    logic                    transpose;
    logic                    start;
    logic                    en;
    logic [DIM*BITS-1:0]     aout;
    logic                    out_valid;
    logic                    busy;
    logic                    full;
    logic                    done;
    logic                    err;

    modport master (
        output wr_en, wr_row, wr_data, transpose, start, en,
        input  aout, out_valid, busy, full, done, err
    );

    modport slave (
        input  wr_en, wr_row, wr_data, transpose, start, en,
        output aout, out_valid, busy, full, done, err
    );
endinterface

// File: rtl/skew_feeder.sv
// skew_feeder: holds a DIM x DIM tile written one row per cycle and streams
// it as a skewed wavefront (lane k delayed k beats, zero outside the tile).
// Ports: clk, rst (sync, active-high), bus (skew_feeder_if.slave):
//   wr_en/wr_row/wr_data row write, transpose/start stream request,
//   en downstream ready, aout/out_valid registered beat, busy/full/done/err.
// Optional: define SKEW_FEEDER_DOUBLE_BUF_EN for two banks, loading during
// streaming and a one-deep queued start that chains tiles back to back.
module skew_feeder #(
    parameter int DIM  = 8,
    parameter int BITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    skew_feeder_if.slave bus
);

`ifdef SKEW_FEEDER_DOUBLE_BUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int TW = $clog2(2*DIM);
    localparam logic [TW-1:0] LAST = TW'(2*DIM-2);

    typedef logic [BITS-1:0] elem_t;
    typedef enum logic {IDLE, STREAM} state_t;

    state_t              state_q, state_d;
    elem_t               mem_q  [NB][DIM][DIM];
    logic [DIM-1:0]      mask_q [NB];
    logic [DIM-1:0]      mask_d [NB];
    logic                ld_q, ld_d;
    logic [TW-1:0]       t_q, t_d;
    logic                tr_q, tr_d;
    logic [DIM*BITS-1:0] aout_q, aout_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
`ifdef SKEW_FEEDER_DOUBLE_BUF_EN
    logic                pend_q, pend_d;
    logic                ptr_q, ptr_d;
    logic                queue;
`endif

    logic                sb;
    logic                full;
    logic                fire;
    logic                last;
    logic                launch;
    logic                launch_tr;
    logic                start_used;
    logic                wr_ok;
    logic                wb;
    logic [TW-1:0]       bt;
    logic                btr;
    logic                bb;
    logic [DIM*BITS-1:0] beat;

    // Request decode. launch means a tile begins on the next edge, either
    // from a start in IDLE or (double buffer) a queued start at tile end.
    always_comb begin
        full = &mask_q[ld_q];
        fire = (state_q == STREAM) && valid_q && bus.en;
        last = fire && (t_q == LAST);
`ifdef SKEW_FEEDER_DOUBLE_BUF_EN
        sb         = ~ld_q;
        queue      = (state_q == STREAM) && bus.start && full && !pend_q;
        launch     = ((state_q == IDLE) && bus.start && full) ||
                     (last && (pend_q || queue));
        launch_tr  = pend_q ? ptr_q : bus.transpose;
        start_used = ((state_q == IDLE) && full) || queue;
`else
        sb         = ld_q;
        launch     = (state_q == IDLE) && bus.start && full;
        launch_tr  = bus.transpose;
        start_used = (state_q == IDLE) && full;
`endif
        // Beat to be registered next: beat 0 of the new tile on launch
        // (drawn from the current load bank), otherwise the next beat.
        bt  = launch ? '0 : t_q + TW'(1);
        btr = launch ? launch_tr : tr_q;
        bb  = launch ? ld_q : sb;
    end

    // Wavefront routing: lane k carries element j of its line when k+j == t.
    always_comb begin
        beat = '0;
        for (int k = 0; k < DIM; k++) begin
            for (int j = 0; j < DIM; j++) begin
                if (int'(bt) == k + j) begin
                    beat[k*BITS +: BITS] = btr ? mem_q[bb][k][j]
                                               : mem_q[bb][j][k];
                end
            end
        end
    end

    // Next state, outputs and mask update.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        tr_d    = tr_q;
        aout_d  = aout_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ld_d    = ld_q;
        mask_d  = mask_q;
        wr_ok   = 1'b0;
        wb      = ld_q;
`ifdef SKEW_FEEDER_DOUBLE_BUF_EN
        pend_d  = pend_q;
        ptr_d   = ptr_q;
`endif

        if (launch) begin
            state_d = STREAM;
            t_d     = '0;
            tr_d    = launch_tr;
            aout_d  = beat;
            valid_d = 1'b1;
`ifdef SKEW_FEEDER_DOUBLE_BUF_EN
            ld_d    = ~ld_q;
            pend_d  = 1'b0;
`endif
        end else if (last) begin
            state_d = IDLE;
            valid_d = 1'b0;
            aout_d  = '0;
        end else if (fire) begin
            t_d    = t_q + TW'(1);
            aout_d = beat;
        end

        // The streamed tile is consumed: clear its mask before any write
        // below so a same-cycle write into the freed bank survives.
        if (last) begin
            done_d     = 1'b1;
            mask_d[sb] = '0;
        end

        if (bus.start && !start_used) begin
            err_d = 1'b1;
        end

`ifdef SKEW_FEEDER_DOUBLE_BUF_EN
        if (queue && !launch) begin
            pend_d = 1'b1;
            ptr_d  = bus.transpose;
        end
        wr_ok = bus.wr_en;
        wb    = ld_d;
`else
        wr_ok = bus.wr_en && (state_q == IDLE);
        if (bus.wr_en && (state_q == STREAM)) begin
            err_d = 1'b1;
        end
`endif
        if (wr_ok) begin
            mask_d[wb][bus.wr_row] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ld_q    <= 1'b0;
            t_q     <= '0;
            tr_q    <= 1'b0;
            aout_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int b = 0; b < NB; b++) begin
                mask_q[b] <= '0;
            end
`ifdef SKEW_FEEDER_DOUBLE_BUF_EN
            pend_q  <= 1'b0;
            ptr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            t_q     <= t_d;
            tr_q    <= tr_d;
            aout_q  <= aout_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int b = 0; b < NB; b++) begin
                mask_q[b] <= mask_d[b];
            end
`ifdef SKEW_FEEDER_DOUBLE_BUF_EN
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                for (int r = 0; r < DIM; r++) begin
                    for (int c = 0; c < DIM; c++) begin
                        mem_q[b][r][c] <= '0;
                    end
                end
            end
        end else if (wr_ok) begin
            for (int c = 0; c < DIM; c++) begin
                mem_q[wb][bus.wr_row][c] <= bus.wr_data[c*BITS +: BITS];
            end
        end
    end

    assign bus.aout      = aout_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = (state_q == STREAM);
    assign bus.full      = full;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_skew_feeder.sv
// tb_skew_feeder: directed checks of skew_feeder with DIM=4, BITS=8.
// Tile M[r][c] = 4r+c+1; expected wavefronts are hand-computed tables.
module tb_skew_feeder;
    localparam int DIM  = 4;
    localparam int BITS = 8;
`ifdef SKEW_FEEDER_DOUBLE_BUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    skew_feeder_if #(.DIM(DIM), .BITS(BITS)) bus();

    skew_feeder #(.DIM(DIM), .BITS(BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_run  = 0;
    int n_fail = 0;

    // Lanes 3..0 packed high to low.
    logic [31:0] exp_n [7] = '{32'h00000001, 32'h00000205, 32'h00030609,
                               32'h04070A0D, 32'h080B0E00, 32'h0C0F0000,
                               32'h10000000};
    logic [31:0] exp_t [7] = '{32'h00000001, 32'h00000502, 32'h00090603,
                               32'h0D0A0704, 32'h0E0B0800, 32'h0F0C0000,
                               32'h10000000};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] row(input int r);
        logic [31:0] v;
        for (int c = 0; c < DIM; c++) v[c*8 +: 8] = 8'(4*r + c + 1);
        return v;
    endfunction

    task automatic load(input int nrows);
        for (int r = 0; r < nrows; r++) begin
            bus.wr_en   = 1'b1;
            bus.wr_row  = 2'(r);
            bus.wr_data = row(r);
            cyc();
        end
        bus.wr_en = 1'b0;
    endtask

    // Expects beat 0 visible on entry; checks all 7 beats and completion.
    task automatic stream(input bit tr, input int stall_at, input int stall_n);
        logic [31:0] e;
        for (int i = 0; i < 7; i++) begin
            e = tr ? exp_t[i] : exp_n[i];
            chkw($sformatf("beat%0d_tr%0d", i, tr), bus.aout, e);
            chkb("beat_valid", bus.out_valid, 1'b1);
            chkb("beat_done", bus.done, 1'b0);
            if (i == stall_at) begin
                bus.en = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    cyc();
                    chkw($sformatf("hold%0d", s), bus.aout, e);
                    chkb("hold_valid", bus.out_valid, 1'b1);
                    chkb("hold_done", bus.done, 1'b0);
                end
                bus.en = 1'b1;
            end
            cyc();
        end
        chkb("end_done", bus.done, 1'b1);
        chkb("end_valid", bus.out_valid, 1'b0);
        chkb("end_busy", bus.busy, 1'b0);
        chkb("end_full", bus.full, 1'b0);
        cyc();
        chkb("done_pulse", bus.done, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_row    = '0;
        bus.wr_data   = '0;
        bus.transpose = 1'b0;
        bus.start     = 1'b0;
        bus.en        = 1'b0;
        cyc();
        cyc();
        chkw("rst_aout", bus.aout, 32'h0);
        chkb("rst_valid", bus.out_valid, 1'b0);
        chkb("rst_busy", bus.busy, 1'b0);
        chkb("rst_full", bus.full, 1'b0);
        chkb("rst_done", bus.done, 1'b0);
        chkb("rst_err", bus.err, 1'b0);
        rst = 1'b0;

        // Plain stream.
        load(4);
        chkb("full_after_load", bus.full, 1'b1);
        bus.en    = 1'b1;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chkb("busy_on_start", bus.busy, 1'b1);
        stream(1'b0, -1, 0);

        // Transposed stream; transpose only held on the start cycle.
        load(4);
        bus.start     = 1'b1;
        bus.transpose = 1'b1;
        cyc();
        bus.start     = 1'b0;
        bus.transpose = 1'b0;
        stream(1'b1, -1, 0);

        // Stall three cycles at beat 2.
        load(4);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        stream(1'b0, 2, 3);

        // Start with an incomplete tile, then with the last row in flight.
        load(3);
        chkb("partial_full", bus.full, 1'b0);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chkb("partial_err", bus.err, 1'b1);
        chkb("partial_busy", bus.busy, 1'b0);
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_row  = 2'd3;
        bus.wr_data = row(3);
        cyc();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        chkb("same_cyc_err", bus.err, 1'b1);
        chkb("same_cyc_busy", bus.busy, 1'b0);
        chkb("same_cyc_full", bus.full, 1'b1);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chkb("retry_err", bus.err, 1'b0);
        chkb("retry_busy", bus.busy, 1'b1);
        stream(1'b0, -1, 0);

        // Illegal start/write mid-stream, then reset abort at beat 4.
        load(4);
        bus.start = 1'b1;
        cyc();
        chkw("ab_beat0", bus.aout, exp_n[0]);
        cyc();
        bus.start = 1'b0;
        chkb("stream_start_err", bus.err, 1'b1);
        chkw("ab_beat1", bus.aout, exp_n[1]);
        bus.wr_en   = 1'b1;
        bus.wr_row  = 2'd0;
        bus.wr_data = 32'hFFFFFFFF;
        cyc();
        bus.wr_en = 1'b0;
        chkb("stream_wr_err", bus.err, !DBL);
        chkw("ab_beat2", bus.aout, exp_n[2]);
        cyc();
        chkb("err_pulse", bus.err, 1'b0);
        chkw("ab_beat3", bus.aout, exp_n[3]);
        cyc();
        chkw("ab_beat4", bus.aout, exp_n[4]);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chkb("abort_valid", bus.out_valid, 1'b0);
        chkb("abort_busy", bus.busy, 1'b0);
        chkb("abort_full", bus.full, 1'b0);
        chkw("abort_aout", bus.aout, 32'h0);
        chkb("abort_done", bus.done, 1'b0);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chkb("abort_start_err", bus.err, 1'b1);
        chkb("abort_start_busy", bus.busy, 1'b0);
        cyc();

`ifdef SKEW_FEEDER_DOUBLE_BUF_EN
        // Tile A streams while tile B loads; B queued at A's beat 3.
        load(4);
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_row  = 2'd0;
        bus.wr_data = row(0);
        cyc();
        for (int i = 0; i < 7; i++) begin
            chkw($sformatf("dbA_beat%0d", i), bus.aout, exp_n[i]);
            chkb("dbA_valid", bus.out_valid, 1'b1);
            chkb("dbA_err", bus.err, 1'b0);
            chkb("dbA_done", bus.done, 1'b0);
            if (i < 3) begin
                bus.wr_en   = 1'b1;
                bus.wr_row  = 2'(i + 1);
                bus.wr_data = row(i + 1);
            end else begin
                bus.wr_en = 1'b0;
            end
            if (i == 3) chkb("dbB_full", bus.full, 1'b1);
            bus.start     = (i == 3);
            bus.transpose = (i == 3);
            cyc();
        end
        for (int i = 0; i < 7; i++) begin
            chkw($sformatf("dbB_beat%0d", i), bus.aout, exp_t[i]);
            chkb("dbB_valid", bus.out_valid, 1'b1);
            chkb("dbB_err", bus.err, 1'b0);
            chkb("dbB_done", bus.done, i == 0);
            cyc();
        end
        chkb("dbB_end_done", bus.done, 1'b1);
        chkb("dbB_end_valid", bus.out_valid, 1'b0);
        chkb("dbB_end_err", bus.err, 1'b0);
        cyc();
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
